output_port_credit: RTL and testbench
=====================================

Name: output_port_credit

Overview:
- Upstream counterpart of the leaf input port: accepts a user payload stream via valid/ack and packetizes each word for a configured destination leaf and port.
- Stamps each packet with a wrapping write address and drives it toward the leaf arbiter/BFT.
- Enforces credit-based flow control so the remote input-port buffer never overflows.
- Credits are returned by freespace-update packets that the remote input port emits after draining FREESPACE_UPDATE_SIZE words.

Parameters:
- PACKET_BITS, 97: total packet width; MSB is the valid bit.
- NUM_LEAF_BITS, 6: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: remote buffer address width; remote depth = 2**NUM_ADDR_BITS words.
- PAYLOAD_BITS, 64: user data width.
- PORT_No, 2: local port number; freespace updates carrying this port are consumed.
- FREESPACE_UPDATE_SIZE, 64: expected credit granularity; used only for the assertion check.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- cfg_vld, input, 1: latch destination configuration.
- cfg_dst_leaf, input, NUM_LEAF_BITS: destination leaf.
- cfg_dst_port, input, NUM_PORT_BITS: destination port.
- din_user, input, PAYLOAD_BITS: user payload.
- vld_user, input, 1: payload valid.
- ack_interface2user, output, 1: word accepted this cycle when high together with vld_user.
- dout_packet, output, PACKET_BITS: packet to arbiter; MSB = valid.
- grant_arb2port, input, 1: arbiter consumed dout_packet this cycle.
- freespace_pkt, input, PACKET_BITS: freespace update from the local leaf demux; MSB = valid.
- credits, output, NUM_ADDR_BITS+1: current credit count, for debug.
- credit_err, output, 1: sticky overflow/protocol error.

Behaviour:
- Packet layout, MSB to LSB: {1'b1, dst_leaf, dst_port, zero pad, addr[NUM_ADDR_BITS-1:0], payload}.
  - addr occupies bits [PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS].
  - Port field occupies bits [PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS].
  - Pad width = PACKET_BITS-1-NUM_LEAF_BITS-NUM_PORT_BITS-NUM_ADDR_BITS-PAYLOAD_BITS; pad is all zeros.
- FSM states UNCONF, RUN, STALL.
  - Reset state is UNCONF. cfg_vld in any state latches the destination fields.
  - UNCONF -> RUN on cfg_vld.
  - RUN -> STALL when credits reach 0 after an accept.
  - STALL -> RUN when credits > 0.
  - cfg_vld in RUN/STALL with the packet register valid: latch only; the in-flight packet keeps its old fields.
- Reset values:
  - dout_packet = 0; ack_interface2user = 0; credit_err = 0.
  - credits = 2**NUM_ADDR_BITS; addr counter = 0; packet register empty.
- Output register: one entry, pkt_vld = dout_packet MSB.
- ack_interface2user is combinational: (state != UNCONF) && credits != 0 && (!pkt_vld || grant_arb2port).
- Accept (vld_user && ack): in the same edge, load dout_packet with the current addr, increment addr mod 2**NUM_ADDR_BITS, decrement credits.
  - Latency from accept to dout_packet valid: 1 cycle.
  - Back-to-back accepts are allowed when grant is high each cycle.
- Grant with no new accept: dout_packet <= 0 at the next edge. Grant while pkt_vld = 0 is ignored.
- Freespace update is valid when: freespace_pkt MSB = 1 and its port field == PORT_No.
  - Amount = freespace_pkt[NUM_ADDR_BITS:0].
  - Credits add the amount at the next edge.
- Accept and update in the same cycle: credits <= credits + amount - 1.
- Saturation: if the result exceeds 2**NUM_ADDR_BITS, credits saturate at 2**NUM_ADDR_BITS and credit_err sets.
- credit_err also sets on an update with amount 0. It clears only on reset.
- Address wrap: address 127 is followed by address 0 at the default width.
- Reset mid-operation: everything returns to reset values asynchronously; any in-flight packet is dropped.
- Credits count as consumed at accept, not at grant, so a packet already held in the register is already paid for.

Decomposition:
- Shared package: packet-field offset localparams (VLD_POS, LEAF_MSB, PORT_MSB, ADDR_LSB, PAD_W), FSM state enum, credit width constant.
- These offsets are common with the input-port decode and must come from the same source.
- One natural sub-module: credit_counter.
  - Inputs: dec, inc_vld, inc_amt.
  - Outputs: count, zero, err.
  - Holds the saturating arithmetic.

Test Plan:
- Reset, then cfg_vld with leaf 5, port 3, then push 3 words 0xA, 0xB, 0xC with grant held high.
  - Required: packets with addr 0, 1, 2, each 1 cycle after accept.
  - Required: leaf/port fields 5/3, pad bits 0; credits end at 125.
- Push data before cfg_vld.
  - Required: ack_interface2user stays 0; dout_packet stays 0.
- Push 128 words with grant always high and no updates.
  - Required: 128 accepts with addrs 0..127; then ack = 0 and state = STALL.
  - Then inject a freespace update for port 2 with amount 64: credits = 64, acks resume, next addr = 0 (wrap).
- Hold grant low with one packet pending.
  - Required: dout_packet stable, ack = 0, no accept.
  - Raise grant in the same cycle vld_user = 1: new packet loaded with no bubble.
- Simultaneous accept and update of 64 at credits = 10.
  - Required: credits = 73.
  - Update for port 1: ignored.
- Update of 64 at credits = 100.
  - Required: credits saturate at 128; credit_err = 1 and stays set until rst_n is asserted.

Source files
------------

// File: rtl/output_port_credit_pkg.sv
// Shared packet-field geometry and port FSM encoding for the output port and
// the matching input-port decode; both sides must derive offsets from here.
package output_port_credit_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_NUM_LEAF_BITS = 6;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;
  localparam int DEF_PAYLOAD_BITS  = 64;

  function automatic int vld_pos(input int packet_bits);
    return packet_bits - 1;
  endfunction

  function automatic int leaf_msb(input int packet_bits);
    return packet_bits - 2;
  endfunction

  function automatic int port_msb(input int packet_bits, input int leaf_bits);
    return packet_bits - 2 - leaf_bits;
  endfunction

  function automatic int pad_w(input int packet_bits, input int leaf_bits,
                               input int port_bits, input int addr_bits,
                               input int payload_bits);
    return packet_bits - 1 - leaf_bits - port_bits - addr_bits - payload_bits;
  endfunction

  localparam int VLD_POS  = vld_pos(DEF_PACKET_BITS);
  localparam int LEAF_MSB = leaf_msb(DEF_PACKET_BITS);
  localparam int PORT_MSB = port_msb(DEF_PACKET_BITS, DEF_NUM_LEAF_BITS);
  localparam int ADDR_LSB = DEF_PAYLOAD_BITS;
  localparam int PAD_W    = pad_w(DEF_PACKET_BITS, DEF_NUM_LEAF_BITS, DEF_NUM_PORT_BITS,
                                  DEF_NUM_ADDR_BITS, DEF_PAYLOAD_BITS);
  localparam int CREDIT_W = DEF_NUM_ADDR_BITS + 1;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2
  } port_state_e;

endpackage

// File: rtl/output_port_credit_credit_counter.sv
// Saturating credit counter: one debit per accept, one batched refund per
// freespace update, ceiling at the remote buffer depth.
module credit_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc_vld,
  input  logic [CW-1:0] inc_amt,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          err
);

  // Two guard bits so depth + max refund never wraps before the compare.
  localparam logic [CW+1:0] MAX_W = (CW+2)'(1) << (CW-1);

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [CW+1:0] sum;
  logic          over;

  always_comb begin
    sum     = {2'b00, count_q} + (inc_vld ? {2'b00, inc_amt} : '0)
              - {{(CW+1){1'b0}}, dec};
    over    = sum > MAX_W;
    count_d = over ? MAX_W[CW-1:0] : sum[CW-1:0];
    err_d   = err_q | over | (inc_vld && (inc_amt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MAX_W[CW-1:0];
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign err   = err_q;

endmodule

// File: rtl/output_port_credit.sv
// Output port: packetizes a user valid/ack stream toward a remote leaf port,
// stamping a wrapping buffer address and metering words with credits.
module output_port_credit
  import output_port_credit_pkg::*;
#(
  parameter int PACKET_BITS           = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
  parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
  parameter int PORT_No               = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_vld,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user,
  output logic                     ack_interface2user,
  output logic [PACKET_BITS-1:0]   dout_packet,
  input  logic                     grant_arb2port,
  input  logic [PACKET_BITS-1:0]   freespace_pkt,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     credit_err,
  output port_state_e              state_o
);

  localparam int CW     = NUM_ADDR_BITS + 1;
  localparam int DEPTH  = 1 << NUM_ADDR_BITS;
  localparam int L_VLD  = vld_pos(PACKET_BITS);
  localparam int L_PMSB = port_msb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int L_PAD  = pad_w(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS,
                                NUM_ADDR_BITS, PAYLOAD_BITS);

  // Handshakes: a user word transfers on a cycle where vld_user and
  // ack_interface2user are both high; a packet leaves on a cycle where
  // dout_packet MSB and grant_arb2port are both high. Ack never depends on
  // vld_user, and grant with no packet held is ignored.

  port_state_e state_q, state_d;

  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

  logic          pkt_vld;
  logic          accept;
  logic          upd_vld;
  logic [CW-1:0] upd_amt;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          next_zero;
  logic [PACKET_BITS-1:0] fs_unused;

  assign fs_unused = freespace_pkt;
  assign pkt_vld   = pkt_q[L_VLD];
  assign upd_vld   = freespace_pkt[L_VLD] &&
                     (freespace_pkt[L_PMSB -: NUM_PORT_BITS] == NUM_PORT_BITS'(PORT_No));
  assign upd_amt   = freespace_pkt[CW-1:0];

  assign ack_interface2user = (state_q != ST_UNCONF) && !cnt_zero && (!pkt_vld || grant_arb2port);
  assign accept             = vld_user && ack_interface2user;

  // Credits land on zero only when the last one is spent and no refund arrives.
  assign next_zero = accept && (cnt == CW'(1)) && !(upd_vld && (upd_amt != '0));

  credit_counter #(.CW(CW)) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec     (accept),
    .inc_vld (upd_vld),
    .inc_amt (upd_amt),
    .count   (cnt),
    .zero    (cnt_zero),
    .err     (credit_err)
  );

  always_comb begin
    state_d = state_q;
    leaf_d  = leaf_q;
    port_d  = port_q;
    addr_d  = addr_q;
    pkt_d   = pkt_q;

    if (cfg_vld) begin
      leaf_d = cfg_dst_leaf;
      port_d = cfg_dst_port;
    end

    case (state_q)
      ST_UNCONF: if (cfg_vld) state_d = ST_RUN;
      ST_RUN:    if (next_zero) state_d = ST_STALL;
      ST_STALL:  if (!cnt_zero && !next_zero) state_d = ST_RUN;
      default:   state_d = ST_UNCONF;
    endcase

    // The packet uses the fields latched before this edge, so a concurrent
    // reconfiguration only affects later words.
    if (accept) begin
      pkt_d  = {1'b1, leaf_q, port_q, {L_PAD{1'b0}}, addr_q, din_user};
      addr_d = addr_q + 1'b1;
    end else if (grant_arb2port && pkt_vld) begin
      pkt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNCONF;
      leaf_q  <= '0;
      port_q  <= '0;
      addr_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      leaf_q  <= leaf_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      pkt_q   <= pkt_d;
    end
  end

  assign dout_packet = pkt_q;
  assign credits     = cnt;
  assign state_o     = state_q;

  credit_granule_fits: assert property (@(posedge clk) disable iff (!rst_n)
    (FREESPACE_UPDATE_SIZE > 0) && (FREESPACE_UPDATE_SIZE <= DEPTH));

endmodule

// File: tb/tb_output_port_credit.sv
// Randomized bench for output_port_credit: behavioural credit/packet model
// plus a scoreboard that retires packets as the arbiter grants them.
module tb_output_port_credit;
  import output_port_credit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_vld;
  logic [5:0]  cfg_dst_leaf;
  logic [3:0]  cfg_dst_port;
  logic [63:0] din_user;
  logic        vld_user;
  logic        ack_interface2user;
  logic [96:0] dout_packet;
  logic        grant_arb2port;
  logic [96:0] freespace_pkt;
  logic [7:0]  credits;
  logic        credit_err;
  port_state_e state_o;

  always #5 clk = ~clk;

  output_port_credit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_vld            (cfg_vld),
    .cfg_dst_leaf       (cfg_dst_leaf),
    .cfg_dst_port       (cfg_dst_port),
    .din_user           (din_user),
    .vld_user           (vld_user),
    .ack_interface2user (ack_interface2user),
    .dout_packet        (dout_packet),
    .grant_arb2port     (grant_arb2port),
    .freespace_pkt      (freespace_pkt),
    .credits            (credits),
    .credit_err         (credit_err),
    .state_o            (state_o)
  );

  int checks = 0;
  int errors = 0;
  logic [96:0] exp_q[$];

  // Reference model state
  int          m_credits;
  int          m_addr;
  bit          m_cfg;
  logic [5:0]  m_leaf;
  logic [3:0]  m_port;
  logic [96:0] m_pkt;
  bit          m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [96:0] mk_pkt(input logic [5:0] leaf, input logic [3:0] port,
                                         input int addr, input logic [63:0] data);
    logic [14:0] pad;
    logic [6:0]  a;
    pad = '0;
    a   = 7'(addr);
    return {1'b1, leaf, port, pad, a, data};
  endfunction

  function automatic logic [96:0] mk_upd(input logic [3:0] port, input logic [7:0] amt);
    logic [96:0] p;
    logic [95:0] junk;
    junk     = {$urandom, $urandom, $urandom};
    p        = '0;
    p[96]    = 1'b1;
    p[95:90] = junk[95:90];
    p[89:86] = port;
    p[85:8]  = junk[77:0];
    p[7:0]   = amt;
    return p;
  endfunction

  // Drive one cycle from a negedge, check against the model, advance the model.
  task automatic cycle(input bit c, input logic [5:0] cl, input logic [3:0] cp,
                       input bit v, input logic [63:0] d, input bit g,
                       input logic [96:0] fs);
    bit exp_ack, acc, upd;
    int amt, nc;
    cfg_vld = c; cfg_dst_leaf = cl; cfg_dst_port = cp;
    vld_user = v; din_user = d; grant_arb2port = g; freespace_pkt = fs;
    #2;
    chk("dout_packet", dout_packet, m_pkt);
    chk("credits", credits, m_credits);
    chk("credit_err", credit_err, m_err);
    exp_ack = m_cfg && (m_credits > 0) && (!m_pkt[96] || g);
    chk("ack", ack_interface2user, exp_ack);
    acc = v && exp_ack;
    upd = fs[96] && (fs[89:86] == 4'd2);
    amt = int'(fs[7:0]);
    if (acc) begin
      m_pkt = mk_pkt(m_leaf, m_port, m_addr, d);
      exp_q.push_back(m_pkt);
      m_addr = (m_addr + 1) % 128;
    end else if (g) begin
      m_pkt = '0;
    end
    nc = m_credits - (acc ? 1 : 0) + (upd ? amt : 0);
    if (upd && amt == 0) m_err = 1'b1;
    if (nc > 128) begin
      nc = 128;
      m_err = 1'b1;
    end
    m_credits = nc;
    if (c) begin
      m_cfg = 1'b1; m_leaf = cl; m_port = cp;
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] d, input bit g);
    cycle(1'b0, 6'd0, 4'd0, 1'b1, d, g, '0);
  endtask

  task automatic idle(input bit g);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, g, '0);
  endtask

  task automatic upd_only(input logic [3:0] port, input logic [7:0] amt);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b1, mk_upd(port, amt));
  endtask

  // Called at a negedge; reset asserts between edges to exercise the async path.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    cfg_vld = 0; cfg_dst_leaf = 0; cfg_dst_port = 0;
    vld_user = 0; din_user = 0; grant_arb2port = 0; freespace_pkt = '0;
    #1;
    exp_q.delete();
    m_credits = 128; m_addr = 0; m_cfg = 0; m_leaf = 0; m_port = 0; m_pkt = '0; m_err = 0;
    chk("rst_dout", dout_packet, 97'd0);
    chk("rst_ack", ack_interface2user, 1'b0);
    chk("rst_credits", credits, 8'd128);
    chk("rst_err", credit_err, 1'b0);
    chk("rst_state", state_o, ST_UNCONF);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: retire the oldest expected packet on each grant.
  always begin
    logic [96:0] e;
    @(negedge clk);
    #3;
    if (rst_n && dout_packet[96] && grant_arb2port) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no packet", dout_packet);
      end else begin
        e = exp_q.pop_front();
        if (dout_packet !== e) begin
          errors++;
          $display("FAIL sb_packet: got %0h expected %0h", dout_packet, e);
        end
      end
    end
  end

  initial begin
    logic [5:0] rl;
    logic [3:0] rp;
    int guard;
    rst_n = 1'b0;
    cfg_vld = 0; cfg_dst_leaf = 0; cfg_dst_port = 0;
    vld_user = 0; din_user = 0; grant_arb2port = 0; freespace_pkt = '0;
    @(negedge clk);
    do_reset();

    // Data before configuration is never acknowledged
    for (int i = 0; i < 6; i++) push({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    chk("unconf_dout", dout_packet, 97'd0);

    // Configure leaf 5 / port 3 and send three words
    cycle(1'b1, 6'd5, 4'd3, 1'b0, 64'd0, 1'b1, '0);
    push(64'hA, 1'b1);
    push(64'hB, 1'b1);
    push(64'hC, 1'b1);
    chk("pkt_c_fields", dout_packet, {1'b1, 6'd5, 4'd3, 15'd0, 7'd2, 64'hC});
    idle(1'b1);
    idle(1'b1);
    chk("credits_after_3", credits, 8'd125);
    chk("sb_drained_3", exp_q.size(), 0);

    // Drain all 128 credits, stall, then refund 64 and wrap the address
    do_reset();
    rl = 6'($urandom); rp = 4'($urandom);
    cycle(1'b1, rl, rp, 1'b0, 64'd0, 1'b1, '0);
    for (int i = 0; i < 128; i++) push({$urandom, $urandom}, 1'b1);
    chk("state_stall", state_o, ST_STALL);
    chk("credits_zero", credits, 8'd0);
    push(64'h1234, 1'b1);
    upd_only(4'd2, 8'd64);
    chk("credits_refund", credits, 8'd64);
    push(64'h5678, 1'b1);
    chk("wrap_addr", dout_packet[70:64], 7'd0);
    chk("state_run", state_o, ST_RUN);

    // Back-pressure: packet held while grant is low; reconfigure meanwhile
    push(64'hDEAD, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) cycle(1'b1, 6'd9, 4'd7, 1'b1, 64'hBEEF, 1'b0, '0);
      else push(64'hBEEF, 1'b0);
    end
    push(64'hF00D, 1'b1);
    chk("newcfg_port", dout_packet[89:86], 4'd7);
    chk("newcfg_leaf", dout_packet[95:90], 6'd9);

    // Accept and refund in the same cycle at 10 credits
    guard = 0;
    while (m_credits > 10 && guard < 200) begin
      push({$urandom, $urandom}, 1'b1);
      guard++;
    end
    chk("credits_ten", credits, 8'd10);
    cycle(1'b0, 6'd0, 4'd0, 1'b1, 64'h77, 1'b1, mk_upd(4'd2, 8'd64));
    chk("credits_73", credits, 8'd73);
    upd_only(4'd1, 8'd64);
    chk("other_port_ignored", credits, 8'd73);

    // Saturation sets the sticky error
    upd_only(4'd2, 8'd27);
    chk("credits_100", credits, 8'd100);
    upd_only(4'd2, 8'd64);
    chk("credits_sat", credits, 8'd128);
    chk("err_set", credit_err, 1'b1);

    // Random traffic; the model tracks credits, packets and the sticky error
    for (int i = 0; i < 400; i++) begin
      logic [96:0] fs;
      int r;
      r = $urandom_range(0, 99);
      if (r < 12)      fs = mk_upd(4'd2, 8'($urandom_range(1, 64)));
      else if (r < 17) fs = mk_upd(4'($urandom_range(3, 15)), 8'($urandom_range(0, 255)));
      else             fs = '0;
      cycle(1'($urandom_range(0, 49) == 0), 6'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            1'($urandom_range(0, 9) < 7), fs);
    end
    chk("err_sticky", credit_err, 1'b1);

    // Reset with a packet in flight drops it
    push(64'hCAFE, 1'b0);
    push(64'hCAFE, 1'b0);
    do_reset();
    idle(1'b1);

    // Zero-amount update is a protocol error
    cycle(1'b1, 6'd1, 4'd1, 1'b0, 64'd0, 1'b1, '0);
    upd_only(4'd2, 8'd0);
    chk("err_zero_amt", credit_err, 1'b1);
    chk("credits_zero_amt", credits, 8'd128);
    push(64'h99, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("sb_drained_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
